// File: rtl/csa_accum_seq_pkg.sv
// Shared definitions for the SHA-2 operand-reduction sequencer.
// Latency: n/a (types, constants and a mask helper only).
// Backpressure: n/a.
package csa_accum_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [63:0] MASK32            = 64'h0000_0000_FFFF_FFFF;
    localparam int          DEFAULT_MAX_BEATS = 4;

    // Word mask for the selected arithmetic width (SHA-512 vs SHA-256).
    function automatic logic [63:0] mode_mask(input logic m64);
        return m64 ? 64'hFFFF_FFFF_FFFF_FFFF : MASK32;
    endfunction

endpackage

// File: rtl/csa_accum_seq_compressor42.sv
// 4:2 carry-save compressor: four operands -> redundant sum/carry pair.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: a..d operands, mode64 selects 64/32-bit width; sum/carry outputs,
// carry already shifted left by one (left-aligned). In 32-bit mode inputs
// are masked and any carry that would land in bit 32 or above is dropped.
module compressor42
    import csa_accum_seq_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] c,
    input  logic [63:0] d,
    input  logic        mode64,
    output logic [63:0] sum,
    output logic [63:0] carry
);

    logic [63:0] m;
    logic [63:0] am, bm, cm, dm;
    logic [63:0] s1, c1, maj1, maj2;

    always_comb begin
        m    = mode_mask(mode64);
        am   = a & m;
        bm   = b & m;
        cm   = c & m;
        dm   = d & m;
        // Stage 1: full-adder row over a, b, c.
        s1   = am ^ bm ^ cm;
        maj1 = (am & bm) | (am & cm) | (bm & cm);
        c1   = {maj1[62:0], 1'b0} & m;
        // Stage 2: fold in d. Bit 63 carry-out is the modular wrap.
        sum   = s1 ^ c1 ^ dm;
        maj2  = (s1 & c1) | (s1 & dm) | (c1 & dm);
        carry = {maj2[62:0], 1'b0} & m;
    end

endmodule

// File: rtl/csa_accum_seq.sv
// Reduces a variable-length operand stream (2 operands/beat) to one modular sum.
// Latency: out_valid rises two clocks after the edge that takes the last beat.
// Backpressure: in_ready low outside IDLE/ACCUM; result held until out_ready.
//
// Ports: clk, rst_n; mode64 (sampled on first beat); in_valid/in_ready with
// in_a, in_b, in_b_en, in_last; out_valid/out_ready with out_data;
// status busy, err (job truncated at MAX_BEATS), beat_cnt.
module csa_accum_seq
    import csa_accum_seq_pkg::*;
#(
    parameter int MAX_BEATS = DEFAULT_MAX_BEATS,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode64,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic             in_b_en,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] beat_cnt
);

    state_t             state_q, state_d;
    logic [63:0]        acc_s, acc_c;
    logic               mode_q;

    logic               first_beat;
    logic               beat_take;
    logic               mode_eff;
    logic [63:0]        b_eff;
    logic [63:0]        cmp_a, cmp_b;
    logic [63:0]        cmp_s, cmp_c;
    logic [CNT_W-1:0]   cnt_next;
    logic               cap_hit;
    logic [63:0]        resolved;

    assign in_ready   = (state_q == IDLE) || (state_q == ACCUM);
    assign busy       = (state_q != IDLE);
    assign beat_take  = in_valid && in_ready;
    assign first_beat = (state_q == IDLE);

    // On the first beat the mode register is not loaded yet, so the live
    // input steers the compressor for that beat only.
    assign mode_eff = first_beat ? mode64 : mode_q;
    assign b_eff    = in_b_en ? in_b : 64'd0;
    assign cmp_a    = first_beat ? 64'd0 : acc_s;
    assign cmp_b    = first_beat ? 64'd0 : acc_c;
    assign cnt_next = first_beat ? CNT_W'(1) : beat_cnt + CNT_W'(1);
    assign cap_hit  = (cnt_next == CNT_W'(MAX_BEATS));
    assign resolved = (acc_s + acc_c) & mode_mask(mode_q);

    compressor42 u_cmp (
        .a      (cmp_a),
        .b      (cmp_b),
        .c      (in_a),
        .d      (b_eff),
        .mode64 (mode_eff),
        .sum    (cmp_s),
        .carry  (cmp_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (beat_take) begin
                    state_d = (in_last || cap_hit) ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: state_d = DONE;
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_s     <= 64'd0;
            acc_c     <= 64'd0;
            out_data  <= 64'd0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            beat_cnt  <= '0;
            mode_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_take) begin
                        acc_s    <= cmp_s;
                        acc_c    <= cmp_c;
                        beat_cnt <= cnt_next;
                        if (first_beat) begin
                            mode_q <= mode64;
                        end
                        if (cap_hit && !in_last) begin
                            err <= 1'b1;
                        end
                    end
                end
                RESOLVE: begin
                    out_data <= resolved;
                end
                DONE: begin
                    // First DONE cycle raises out_valid; the result then
                    // waits for out_ready before the job is retired.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        err       <= 1'b0;
                        beat_cnt  <= '0;
                        acc_s     <= 64'd0;
                        acc_c     <= 64'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
